// File: rtl/systolic_psum_collector_pkg.sv
// Shared types and defaults for the systolic array output-side collector.
package systolic_psum_collector_pkg;

  localparam int DEF_DATA_WIDTH_A = 8;
  localparam int DEF_DATA_WIDTH_W = 8;
  localparam int DEF_DATA_WIDTH_P = 32;
  localparam int DEF_ROW_NUM      = 32;
  localparam int DEF_COL_NUM      = 32;

  // Collector job sequencing states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } psum_state_t;

  // Cycle (relative to start) at which vector 0 is fully deskewed.
  function automatic int align_cycle(input int array_lat, input int col_num);
    return array_lat + col_num - 1;
  endfunction

endpackage

// File: rtl/systolic_psum_collector_psum_fifo.sv
// First-word-fall-through FIFO for aligned partial-sum vectors.
// A write while full succeeds only when a read frees a slot in the same cycle.
module psum_fifo #(
  parameter int W     = 1025,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  // Head is gated so nothing stale is visible while empty (outputs read 0).
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/systolic_psum_collector.sv
// Captures skewed column partial sums from the systolic array, deskews them
// and streams aligned vectors out over valid/ready.
// Stream: a vector transfers in a cycle where out_valid && out_ready; once
// out_valid is high it stays high with stable out_data/out_last until taken.
module systolic_psum_collector
  import systolic_psum_collector_pkg::*;
#(
  parameter int COL_NUM      = DEF_COL_NUM,
  parameter int DATA_WIDTH_P = DEF_DATA_WIDTH_P,
  parameter int ARRAY_LAT    = 32,
  parameter int FIFO_DEPTH   = 64,
  parameter int CNT_W        = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [CNT_W-1:0]                num_vec,
  input  logic [COL_NUM*DATA_WIDTH_P-1:0] col_in_flat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COL_NUM*DATA_WIDTH_P-1:0] out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overflow
);

  localparam int VW = COL_NUM * DATA_WIDTH_P;
  localparam int T0 = align_cycle(ARRAY_LAT, COL_NUM);
  localparam int TW = $clog2(T0 + 1) + 1;

  psum_state_t      state;
  logic [TW-1:0]    wait_cnt;
  logic [CNT_W-1:0] cap_cnt;
  logic [CNT_W-1:0] nv_r;
  logic [VW-1:0]    aligned;
  logic             cap_wr;
  logic             cap_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic [VW:0]      fifo_head;

  // Lane c is delayed by COL_NUM-1-c stages so all lanes of a vector line up.
  for (genvar c = 0; c < COL_NUM; c++) begin : g_lane
    localparam int D = COL_NUM - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c*DATA_WIDTH_P +: DATA_WIDTH_P] = col_in_flat[c*DATA_WIDTH_P +: DATA_WIDTH_P];
    end else begin : g_dly
      logic [DATA_WIDTH_P-1:0] dly [D];
      // Per-lane shift register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) dly[i] <= '0;
        end else begin
          dly[0] <= col_in_flat[c*DATA_WIDTH_P +: DATA_WIDTH_P];
          for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
        end
      end
      assign aligned[c*DATA_WIDTH_P +: DATA_WIDTH_P] = dly[D-1];
    end
  end

  assign cap_wr   = (state == S_CAPTURE);
  assign cap_last = (cap_cnt == nv_r - CNT_W'(1));
  assign busy     = (state != S_IDLE);

  // Job sequencing; wait_cnt tracks cycles since start so CAPTURE begins at T0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      cap_cnt  <= '0;
      nv_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (num_vec != '0)) begin
            state    <= S_WAIT;
            wait_cnt <= TW'(1);
            nv_r     <= num_vec;
          end
        end
        S_WAIT: begin
          if (wait_cnt == TW'(T0 - 1)) begin
            state   <= S_CAPTURE;
            cap_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          cap_cnt <= cap_cnt + 1'b1;
          if (cap_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fifo_empty) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky overflow: a capture found the FIFO full with no read freeing a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (cap_wr && fifo_full && !out_ready) begin
      overflow <= 1'b1;
    end
  end

  psum_fifo #(
    .W     (VW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap_wr),
    .wr_data ({cap_last, aligned}),
    .rd_en   (out_ready),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[VW-1:0];
  assign out_last  = fifo_head[VW];

endmodule

// File: tb/tb_systolic_psum_collector.sv
// Bench for systolic_psum_collector: models the array's skewed output timing
// and checks the aligned stream against a queue of expected vectors.
module tb_systolic_psum_collector;

  localparam int CN    = 32;
  localparam int DW    = 32;
  localparam int AL    = 32;
  localparam int DEPTH = 64;
  localparam int CW    = 8;
  localparam int T0    = AL + CN - 1;
  localparam int VW    = CN * DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CW-1:0]     num_vec;
  logic [VW-1:0]     col_in_flat;
  logic              out_valid;
  logic              out_ready;
  logic [VW-1:0]     out_data;
  logic              out_last;
  logic              busy;
  logic              overflow;

  // clock / reset
  always #5 clk = ~clk;

  systolic_psum_collector #(
    .COL_NUM(CN), .DATA_WIDTH_P(DW), .ARRAY_LAT(AL), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .col_in_flat(col_in_flat), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  // scoreboard and reference state
  logic [VW:0]   exp_q[$];
  logic [DW-1:0] jobd [256][CN];
  int  checks = 0;
  int  errors = 0;
  bit  m_active;
  int  m_t;
  int  m_n;
  bit  m_ovf;
  int  mode;
  int  ready_pct;
  int  rx_count;
  bit  seen_last;
  int  first_valid_t;
  int  ovf_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VW:0] obs, input logic [VW:0] exp);
    int lane;
    checks++;
    assert (obs === exp) else begin
      errors++;
      lane = CN;
      for (int c = CN - 1; c >= 0; c--)
        if (obs[c*DW +: DW] !== exp[c*DW +: DW]) lane = c;
      if (lane == CN)
        $error("FAIL %s last observed=%0b expected=%0b", tag, obs[VW], exp[VW]);
      else
        $error("FAIL %s lane %0d observed=%0h expected=%0h", tag, lane,
               obs[lane*DW +: DW], exp[lane*DW +: DW]);
    end
  endtask

  // Vector contents for a job: what the array would produce for vector k, column c.
  task automatic gen_job(input int n);
    int s;
    for (int k = 0; k < n; k++)
      for (int c = 0; c < CN; c++) begin
        if (mode == 1) begin
          s = 0;
          for (int r = 0; r < 32; r++) s += (r % 8) * (k % 8);
          jobd[k][c] = DW'(s);
        end else if (mode == 2) begin
          jobd[k][c] = DW'(1000 * c + k);
        end else begin
          jobd[k][c] = $urandom;
        end
      end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the reference.
  task automatic cycle(input bit st, input logic [CW-1:0] nv);
    int k;
    bit pop;
    bit was_empty;
    logic [VW:0] v;
    start     = st;
    num_vec   = nv;
    out_ready = ($urandom_range(99) < ready_pct);
    for (int c = 0; c < CN; c++) begin
      k = m_t - AL - c;
      if (m_active && k >= 0 && k < m_n) col_in_flat[c*DW +: DW] = jobd[k][c];
      else col_in_flat[c*DW +: DW] = $urandom;
    end
    #1;
    chk("busy", busy, m_active);
    chk("overflow", overflow, m_ovf);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (out_valid === 1'b1 && exp_q.size() != 0)
      chk_vec("head", {out_last, out_data}, exp_q[0]);
    if (out_valid === 1'b1 && first_valid_t < 0 && m_active) first_valid_t = m_t;
    if (overflow === 1'b1 && ovf_t < 0 && m_active) ovf_t = m_t;
    was_empty = (exp_q.size() == 0);
    pop = !was_empty && out_ready;
    if (pop) begin
      if (exp_q[0][VW]) seen_last = 1'b1;
      rx_count++;
      void'(exp_q.pop_front());
    end
    if (m_active) begin
      if (m_t >= T0 && m_t < T0 + m_n) begin
        k = m_t - T0;
        v[VW] = (k == m_n - 1);
        for (int c = 0; c < CN; c++) v[c*DW +: DW] = jobd[k][c];
        if (exp_q.size() == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(v);
      end
      if (m_t >= T0 + m_n && was_empty) m_active = 1'b0;
      m_t++;
    end else if (st && nv != '0) begin
      m_active = 1'b1;
      m_t = 1;
      m_n = int'(nv);
      gen_job(m_n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_data_or", |out_data, 0);
    exp_q.delete();
    m_active = 1'b0;
    m_t = 0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_job(input int n, input int exp_rx);
    rx_count = 0;
    seen_last = 1'b0;
    first_valid_t = -1;
    cycle(1'b1, CW'(n));
    for (int i = 0; i < 3000 && m_active; i++) cycle(1'b0, '0);
    chk("job_end_busy", busy, 0);
    chk("job_rx_count", rx_count, exp_rx);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_vec = '0;
    out_ready = 1'b0;
    col_in_flat = '0;
    m_active = 1'b0;
    m_t = 0;
    m_n = 0;
    m_ovf = 1'b0;
    mode = 0;
    ready_pct = 100;
    first_valid_t = -1;
    ovf_t = -1;
    do_reset();
    @(posedge clk);
    #1;

    // 1) uniform weights/activations, always ready
    mode = 1;
    ready_pct = 100;
    run_job(32, 32);
    chk("first_valid_latency", first_valid_t, T0 + 1);
    chk("t1_last_seen", seen_last, 1);

    // 2) lane-distinct data, started the cycle after busy falls
    mode = 2;
    run_job(32, 32);
    chk("t2_last_seen", seen_last, 1);

    // 3) consumer stalled for the whole job: FIFO fills, overflow, last dropped
    mode = 0;
    ready_pct = 0;
    rx_count = 0;
    seen_last = 1'b0;
    ovf_t = -1;
    cycle(1'b1, CW'(DEPTH + 4));
    repeat (T0 + DEPTH + 10) cycle(1'b0, '0);
    chk("t3_busy_held", busy, 1);
    chk("t3_overflow_time", ovf_t, T0 + DEPTH + 1);
    ready_pct = 100;
    for (int i = 0; i < 500 && m_active; i++) cycle(1'b0, '0);
    chk("t3_end_busy", busy, 0);
    chk("t3_rx_count", rx_count, DEPTH);
    chk("t3_last_seen", seen_last, 0);
    do_reset();

    // 4) random backpressure
    ready_pct = 50;
    run_job(40, 40);
    chk("t4_overflow", overflow, 0);
    chk("t4_last_seen", seen_last, 1);

    // 5) extra start pulses during WAIT/CAPTURE are ignored; num_vec=0 is ignored
    ready_pct = 100;
    rx_count = 0;
    cycle(1'b1, CW'(40));
    for (int i = 0; i < 1000 && m_active; i++)
      cycle((m_t == 10) || (m_t == T0 + 3), CW'(5));
    chk("t5_end_busy", busy, 0);
    chk("t5_rx_count", rx_count, 40);
    cycle(1'b1, '0);
    repeat (4) cycle(1'b0, '0);
    chk("t5_zero_job_busy", busy, 0);

    // 6) reset in the middle of CAPTURE, then a clean job
    cycle(1'b1, CW'(32));
    for (int i = 0; i < 200 && m_t < T0 + 10; i++) cycle(1'b0, '0);
    do_reset();
    @(posedge clk);
    #1;
    ready_pct = 70;
    run_job(16, 16);
    chk("t6_last_seen", seen_last, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
